// File: rtl/axi_slave_mem_if.sv
// ---------------------------------------------------------------------------
// axi_slave_mem_if
//   Five-channel AXI bus bundle between a master driver and axi_slave_mem.
//   Clock and reset are not part of the bundle; they stay scalar ports.
//
//   Parameter: ID_W - width of every ID field.
//   Channels : AW (awid/awaddr/awlen/awsize/awburst/awvalid -> awready)
//              W  (wid/wdata/wstrb/wlast/wvalid             -> wready)
//              B  (bid/bresp/bvalid                         <- bready)
//              AR (arid/araddr/arlen/arsize/arburst/arvalid -> arready)
//              R  (rid/rdata/rresp/rlast/rvalid             <- rready)
//   Modports : master (driver side), slave (memory side), monitor (observe).
// ---------------------------------------------------------------------------
interface axi_slave_mem_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wid, wdata, wstrb, wlast, wvalid,             input wready,
    input  bid, bresp, bvalid,                           output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid,             output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wid, wdata, wstrb, wlast, wvalid,             output wready,
    output bid, bresp, bvalid,                           input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid,             input  rready
  );

  modport monitor (
    input awid, awaddr, awlen, awsize, awburst, awvalid, awready,
    input wid, wdata, wstrb, wlast, wvalid, wready,
    input bid, bresp, bvalid, bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, arready,
    input rid, rdata, rresp, rlast, rvalid, rready
  );
endinterface

// File: rtl/axi_slave_mem.sv
// ---------------------------------------------------------------------------
// axi_slave_mem
//   AXI slave backed by a word-addressed 32-bit memory. One write burst and
//   one read burst may be in flight at a time, each with its own FSM.
//   Bad beats (size>2, out-of-range address, reserved/unsupported burst,
//   wlast or wid mismatch on writes) are answered with SLVERR; writes of bad
//   beats are dropped and reads of bad beats return zero.
//
//   Ports : clock   - single clock, rising edge
//           aresetn - synchronous active-low reset (memory is not cleared)
//           bus     - axi_slave_mem_if.slave, all five AXI channels
//   Params: MEM_DEPTH - number of 32-bit words
//           ID_W      - ID field width (must match the interface)
//   Macro : AXI_SLV_WRAP_EN - when defined, WRAP bursts (len 1/3/7/15) are
//           supported; otherwise WRAP bursts are consumed and answered SLVERR.
// ---------------------------------------------------------------------------
module axi_slave_mem #(
  parameter int MEM_DEPTH = 1024,
  parameter int ID_W      = 4
) (
  input  logic           clock,
  input  logic           aresetn,
  axi_slave_mem_if.slave bus
);

`ifdef AXI_SLV_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam int          IDX_W       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] ADDR_LIMIT  = 32'(MEM_DEPTH) << 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;
  localparam logic [1:0]  BURST_RSVD  = 2'b11;

  // Burst-level error: applies to every beat of the burst.
  function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > 3'd2) || (burst == BURST_RSVD) ||
           ((burst == BURST_WRAP) && !(WRAP_EN && wrap_len_ok));
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst, input logic [7:0] len);
    logic [31:0] bytes, incr, wrap_mask, nxt;
    bytes     = 32'd1 << size;
    incr      = addr + bytes;
    wrap_mask = ((32'(len) + 32'd1) * bytes) - 32'd1;
    case (burst)
      BURST_FIXED: nxt = addr;
      BURST_INCR:  nxt = incr;
      BURST_WRAP:  nxt = WRAP_EN ? ((addr & ~wrap_mask) | (incr & wrap_mask)) : addr;
      default:     nxt = addr;
    endcase
    return nxt;
  endfunction

  logic [31:0] mem [MEM_DEPTH];

  // ---------------------------------------------------------------- write ---
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  w_state_t        w_state, w_next;
  logic [ID_W-1:0] w_id;
  logic [31:0]     w_addr;
  logic [7:0]      w_len, w_cnt;
  logic [2:0]      w_size;
  logic [1:0]      w_burst;
  logic            w_err;
  logic            awready, wready, bvalid;
  logic            aw_fire, w_fire, w_last_beat, w_beat_err;

  assign aw_fire     = bus.awvalid && awready;
  assign w_fire      = bus.wvalid && wready;
  assign w_last_beat = (w_cnt == w_len);
  assign w_beat_err  = burst_bad(w_size, w_burst, w_len) || (w_addr >= ADDR_LIMIT) ||
                       (bus.wlast != w_last_beat) || (bus.wid != w_id);

  always_ff @(posedge clock) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // w_next unassigned, which would otherwise infer a latch.
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire)                w_next = W_DATA;
      W_DATA:  if (w_fire && w_last_beat)  w_next = W_RESP;
      W_RESP:  if (bus.bready)             w_next = W_IDLE;
      default:                             w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (w_state == W_IDLE);
    wready  = (w_state == W_DATA);
    bvalid  = (w_state == W_RESP);
  end

  always_ff @(posedge clock) begin
    if (!aresetn) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else if (aw_fire) begin
      w_id    <= bus.awid;
      w_addr  <= bus.awaddr;
      w_len   <= bus.awlen;
      w_size  <= bus.awsize;
      w_burst <= bus.awburst;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (w_fire) begin
      w_addr  <= next_addr(w_addr, w_size, w_burst, w_len);
      w_cnt   <= w_cnt + 8'd1;
      w_err   <= w_err | w_beat_err;
    end
  end

  // NOTE: the storage array is deliberately left out of reset so it maps
  // onto RAM; aresetn only gates the write enable.
  always_ff @(posedge clock) begin
    if (aresetn && w_fire && !w_beat_err) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[w_addr[IDX_W+1:2]][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  assign bus.awready = awready;
  assign bus.wready  = wready;
  assign bus.bvalid  = bvalid;
  assign bus.bid     = w_id;
  assign bus.bresp   = w_err ? RESP_SLVERR : RESP_OKAY;

  // ----------------------------------------------------------------- read ---
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  r_state_t        r_state, r_next;
  logic [ID_W-1:0] r_id;
  logic [31:0]     r_addr, r_step_addr, fetch_addr, rdata_q;
  logic [7:0]      r_len, r_cnt;
  logic [2:0]      r_size;
  logic [1:0]      r_burst, rresp_q;
  logic            arready, rvalid, rlast;
  logic            ar_fire, r_fire, r_last_beat, fetch_en, fetch_err;

  assign ar_fire     = bus.arvalid && arready;
  assign r_fire      = rvalid && bus.rready;
  assign r_last_beat = (r_cnt == r_len);
  assign r_step_addr = next_addr(r_addr, r_size, r_burst, r_len);
  // The first beat is fetched straight off the AR channel; later beats are
  // prefetched on each handshake so rvalid can stay high back-to-back.
  assign fetch_addr  = ar_fire ? bus.araddr : r_step_addr;
  assign fetch_en    = ar_fire || (r_fire && !r_last_beat);
  assign fetch_err   = (ar_fire ? burst_bad(bus.arsize, bus.arburst, bus.arlen)
                                : burst_bad(r_size, r_burst, r_len)) ||
                       (fetch_addr >= ADDR_LIMIT);

  always_ff @(posedge clock) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire)               r_next = R_DATA;
      R_DATA:  if (r_fire && r_last_beat) r_next = R_IDLE;
      default:                            r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
    rlast   = (r_state == R_DATA) && r_last_beat;
  end

  // A same-cycle write to the fetched word is not visible here: the array
  // read sees the value before this edge's write lands.
  always_ff @(posedge clock) begin
    if (!aresetn) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      if (ar_fire) begin
        r_id    <= bus.arid;
        r_len   <= bus.arlen;
        r_size  <= bus.arsize;
        r_burst <= bus.arburst;
        r_cnt   <= '0;
      end else if (r_fire) begin
        r_cnt   <= r_cnt + 8'd1;
      end
      if (fetch_en) begin
        r_addr  <= fetch_addr;
        rdata_q <= fetch_err ? 32'd0 : mem[fetch_addr[IDX_W+1:2]];
        rresp_q <= fetch_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign bus.arready = arready;
  assign bus.rvalid  = rvalid;
  assign bus.rlast   = rlast;
  assign bus.rid     = r_id;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_mem
//   Directed bench for axi_slave_mem: reset values, a table of write/readback
//   bursts, then hand-written sequences for strobes/FIXED, error cases, read
//   backpressure with a concurrent write, B-channel stall and WRAP bursts
//   (expectations follow AXI_SLV_WRAP_EN).
// ---------------------------------------------------------------------------
module tb_axi_slave_mem;
  localparam int         MEM_DEPTH = 1024;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  logic clock = 1'b0;
  logic aresetn;
  always #5 clock = ~clock;

  axi_slave_mem_if #(.ID_W(4)) bus ();

  axi_slave_mem #(.MEM_DEPTH(MEM_DEPTH), .ID_W(4)) dut (
    .clock   (clock),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];

  typedef struct {
    string       name;
    logic [3:0]  wr_id;
    logic [3:0]  rd_id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] base;       // beat i writes base+i, all lanes
    logic [1:0]  exp_bresp;
    logic [15:0] ok_beats;   // bit i: read beat i returns base+i with OKAY
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [15:0] wlast_pat, input logic [3:0] wid, input int bstall,
                          output logic [1:0] resp, output logic [3:0] bid);
    @(negedge clock);
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    for (int g = 0; g < 50 && !bus.awready; g++) @(negedge clock);
    check("awready", 32'(bus.awready), 32'd1);
    @(negedge clock);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wid = wid; bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = wlast_pat[i];
      bus.wvalid = 1'b1;
      for (int g = 0; g < 50 && !bus.wready; g++) @(negedge clock);
      check("wready", 32'(bus.wready), 32'd1);
      @(negedge clock);
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    for (int g = 0; g < 50 && !bus.bvalid; g++) @(negedge clock);
    check("bvalid", 32'(bus.bvalid), 32'd1);
    for (int k = 0; k < bstall; k++) begin
      check("bvalid held", 32'(bus.bvalid), 32'd1);
      check("awready low in resp", 32'(bus.awready), 32'd0);
      @(negedge clock);
    end
    resp = bus.bresp;
    bid  = bus.bid;
    bus.bready = 1'b1;
    @(negedge clock);
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    @(negedge clock);
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    for (int g = 0; g < 50 && !bus.arready; g++) @(negedge clock);
    check("arready", 32'(bus.arready), 32'd1);
    @(negedge clock);
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      for (int g = 0; g < 50 && !bus.rvalid; g++) @(negedge clock);
      check("rvalid", 32'(bus.rvalid), 32'd1);
      rd_data[i] = bus.rdata; rd_resp[i] = bus.rresp; rd_last[i] = bus.rlast; rd_id[i] = bus.rid;
      @(negedge clock);
    end
    bus.rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [3:0]  bid;
    logic [31:0] bp_exp [6];
    logic [5:0]  bp_rdy;

    vt[0] = '{"incr4",  4'd5, 4'd6, 32'h100,  8'd3, 3'd2, INCR, 32'hA0,       OKAY,   16'h000F};
    vt[1] = '{"single", 4'd1, 4'd2, 32'h200,  8'd0, 3'd2, INCR, 32'h12345678, OKAY,   16'h0001};
    vt[2] = '{"size3",  4'd3, 4'd4, 32'h300,  8'd1, 3'd3, INCR, 32'h55,       SLVERR, 16'h0000};
    vt[3] = '{"oob",    4'd7, 4'd8, 32'h1000, 8'd0, 3'd2, INCR, 32'h66,       SLVERR, 16'h0000};
    vt[4] = '{"rsvd",   4'd9, 4'hA, 32'h40,   8'd0, 3'd2, RSVD, 32'h77,       SLVERR, 16'h0000};
    vt[5] = '{"edge",   4'hB, 4'hC, 32'hFFC,  8'd1, 3'd2, INCR, 32'hE0,       SLVERR, 16'h0001};

    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    // Reset
    aresetn = 1'b0;
    repeat (3) @(negedge clock);
    check("rst awready", 32'(bus.awready), 32'd1);
    check("rst arready", 32'(bus.arready), 32'd1);
    check("rst wready",  32'(bus.wready),  32'd0);
    check("rst bvalid",  32'(bus.bvalid),  32'd0);
    check("rst rvalid",  32'(bus.rvalid),  32'd0);
    check("rst rlast",   32'(bus.rlast),   32'd0);
    check("rst bresp",   32'(bus.bresp),   32'd0);
    check("rst rdata",   bus.rdata,        32'd0);
    aresetn = 1'b1;

    // Table: write burst, then read it back with the same fields
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 16; i++) begin
        wd[i] = vt[v].base + 32'(i);
        ws[i] = 4'hF;
      end
      do_write(vt[v].wr_id, vt[v].addr, vt[v].len, vt[v].size, vt[v].burst,
               16'h1 << vt[v].len, vt[v].wr_id, 0, resp, bid);
      check({vt[v].name, " bresp"}, 32'(resp), 32'(vt[v].exp_bresp));
      check({vt[v].name, " bid"},   32'(bid),  32'(vt[v].wr_id));
      do_read(vt[v].rd_id, vt[v].addr, vt[v].len, vt[v].size, vt[v].burst);
      for (int i = 0; i <= int'(vt[v].len); i++) begin
        check($sformatf("%s rdata[%0d]", vt[v].name, i), rd_data[i],
              vt[v].ok_beats[i] ? vt[v].base + 32'(i) : 32'd0);
        check($sformatf("%s rresp[%0d]", vt[v].name, i), 32'(rd_resp[i]),
              vt[v].ok_beats[i] ? 32'(OKAY) : 32'(SLVERR));
        check($sformatf("%s rlast[%0d]", vt[v].name, i), 32'(rd_last[i]),
              32'(i == int'(vt[v].len)));
        check($sformatf("%s rid[%0d]", vt[v].name, i), 32'(rd_id[i]), 32'(vt[v].rd_id));
      end
    end

    // Byte strobes on a FIXED burst
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(4'd1, 32'h20, 8'd0, 3'd2, INCR, 16'h1, 4'd1, 0, resp, bid);
    check("strobe init bresp", 32'(resp), 32'(OKAY));
    wd[0] = 32'h000000FF; ws[0] = 4'b0001;
    wd[1] = 32'h0000EE00; ws[1] = 4'b0010;
    do_write(4'd2, 32'h20, 8'd1, 3'd2, FIXED, 16'h2, 4'd2, 0, resp, bid);
    check("fixed bresp", 32'(resp), 32'(OKAY));
    do_read(4'd3, 32'h20, 8'd0, 3'd2, INCR);
    check("fixed rdata", rd_data[0], 32'h1122EEFF);

    // Out-of-range write must not touch the word it would alias onto
    wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
    do_write(4'd1, 32'h0, 8'd0, 3'd2, INCR, 16'h1, 4'd1, 0, resp, bid);
    check("word0 bresp", 32'(resp), 32'(OKAY));
    wd[0] = 32'hDEADBEEF;
    do_write(4'd1, 32'(MEM_DEPTH * 4), 8'd0, 3'd2, INCR, 16'h1, 4'd1, 0, resp, bid);
    check("oob bresp", 32'(resp), 32'(SLVERR));
    do_read(4'd1, 32'h0, 8'd0, 3'd2, INCR);
    check("oob mem unchanged", rd_data[0], 32'hCAFEF00D);

    // Early wlast on beat 1 of a 3-beat burst; mismatched wid
    for (int i = 0; i < 16; i++) begin wd[i] = 32'h90 + 32'(i); ws[i] = 4'hF; end
    do_write(4'd3, 32'h400, 8'd2, 3'd2, INCR, 16'h2, 4'd3, 0, resp, bid);
    check("early wlast bresp", 32'(resp), 32'(SLVERR));
    do_write(4'd4, 32'h404, 8'd0, 3'd2, INCR, 16'h1, 4'd5, 0, resp, bid);
    check("wid mismatch bresp", 32'(resp), 32'(SLVERR));

    // Read backpressure (rready 1,0,0,1,1,1) with a concurrent write burst
    bp_exp = '{32'hA0, 32'hA1, 32'hA1, 32'hA1, 32'hA2, 32'hA3};
    bp_rdy = 6'b111001;
    for (int i = 0; i < 16; i++) begin wd[i] = 32'hC0 + 32'(i); ws[i] = 4'hF; end
    fork
      begin
        @(negedge clock);
        bus.arid = 4'd9; bus.araddr = 32'h100; bus.arlen = 8'd3; bus.arsize = 3'd2;
        bus.arburst = INCR; bus.arvalid = 1'b1;
        for (int g = 0; g < 50 && !bus.arready; g++) @(negedge clock);
        check("bp arready", 32'(bus.arready), 32'd1);
        @(negedge clock);
        bus.arvalid = 1'b0;
        for (int i = 0; i < 6; i++) begin
          bus.rready = bp_rdy[i];
          check($sformatf("bp rvalid[%0d]", i), 32'(bus.rvalid), 32'd1);
          check($sformatf("bp rdata[%0d]", i), bus.rdata, bp_exp[i]);
          check($sformatf("bp rlast[%0d]", i), 32'(bus.rlast), 32'(i == 5));
          @(negedge clock);
        end
        bus.rready = 1'b0;
        check("bp rvalid after last", 32'(bus.rvalid), 32'd0);
        check("bp arready after last", 32'(bus.arready), 32'd1);
      end
      begin
        do_write(4'd2, 32'h500, 8'd3, 3'd2, INCR, 16'h8, 4'd2, 0, resp, bid);
        check("concurrent bresp", 32'(resp), 32'(OKAY));
      end
    join
    do_read(4'd2, 32'h500, 8'd3, 3'd2, INCR);
    for (int i = 0; i < 4; i++)
      check($sformatf("concurrent rdata[%0d]", i), rd_data[i], 32'hC0 + 32'(i));

    // B-channel stall: bvalid held, awready low for 5 cycles
    wd[0] = 32'h600D600D; ws[0] = 4'hF;
    do_write(4'd6, 32'h600, 8'd0, 3'd2, INCR, 16'h1, 4'd6, 5, resp, bid);
    check("stall bresp", 32'(resp), 32'(OKAY));
    check("stall bid",   32'(bid),  32'd6);

    // WRAP bursts
`ifdef AXI_SLV_WRAP_EN
    for (int i = 0; i < 16; i++) begin wd[i] = 32'hB0 + 32'(i); ws[i] = 4'hF; end
    do_write(4'd7, 32'h38, 8'd3, 3'd2, WRAP, 16'h8, 4'd7, 0, resp, bid);
    check("wrap bresp", 32'(resp), 32'(OKAY));
    // Beats landed at 0x38, 0x3C, 0x30, 0x34.
    do_read(4'd7, 32'h30, 8'd3, 3'd2, INCR);
    for (int i = 0; i < 4; i++)
      check($sformatf("wrap mem[%0d]", i), rd_data[i], 32'hB0 + 32'((i + 2) % 4));
    do_write(4'd7, 32'h38, 8'd2, 3'd2, WRAP, 16'h4, 4'd7, 0, resp, bid);
    check("wrap len2 bresp", 32'(resp), 32'(SLVERR));
`else
    for (int i = 0; i < 16; i++) begin wd[i] = 32'd0; ws[i] = 4'hF; end
    do_write(4'd7, 32'h30, 8'd3, 3'd2, INCR, 16'h8, 4'd7, 0, resp, bid);
    check("wrap clear bresp", 32'(resp), 32'(OKAY));
    for (int i = 0; i < 16; i++) wd[i] = 32'hB0 + 32'(i);
    do_write(4'd7, 32'h38, 8'd3, 3'd2, WRAP, 16'h8, 4'd7, 0, resp, bid);
    check("wrap off bresp", 32'(resp), 32'(SLVERR));
    do_read(4'd7, 32'h30, 8'd3, 3'd2, INCR);
    for (int i = 0; i < 4; i++)
      check($sformatf("wrap off mem[%0d]", i), rd_data[i], 32'd0);
    do_read(4'd8, 32'h38, 8'd3, 3'd2, WRAP);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap off rresp[%0d]", i), 32'(rd_resp[i]), 32'(SLVERR));
      check($sformatf("wrap off rdata[%0d]", i), rd_data[i], 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- Synthesisable AXI slave memory; the DUT endpoint driven by the master driver through the bench's AXI interface.
- Accepts write and read bursts on five independent channels and stores data in an internal word-addressed array.
- Returns OKAY or SLVERR responses.
- The slave monitor observes this block's ready, response and read-data outputs.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words; the valid byte range is 0 .. MEM_DEPTH*4-1.
- ID_W, 4, width of all ID fields.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- aresetn  in  1  synchronous, active-low reset.
- awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_W/32/8/3/2/1  write address channel.
- awready  out  1  write address ready.
- wid/wdata/wstrb/wlast/wvalid  in  ID_W/32/4/1/1  write data channel.
- wready  out  1  write data ready.
- bid/bresp/bvalid  out  ID_W/2/1  write response channel.
- bready  in  1  write response ready.
- arid/araddr/arlen/arsize/arburst/arvalid  in  ID_W/32/8/3/2/1  read address channel.
- arready  out  1  read address ready.
- rid/rdata/rresp/rlast/rvalid  out  ID_W/32/2/1/1  read data channel.
- rready  in  1  read data ready.

Behaviour:
- Reset: while aresetn=0 at a clock edge:
  - both FSMs go to IDLE;
  - awready=1, arready=1;
  - wready, bvalid, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata = 0.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the burst; beats already written stay written.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On awvalid&&awready, latch id, addr, len, size and burst; clear beat count and error flag. Next cycle: awready=0, wready=1.
  - W_DATA: wready=1. For each wvalid&&wready beat, write byte lanes enabled by wstrb to mem[addr[31:2]], then advance the address.
  - W_DATA exit: when beat count==len, wready=0 and go to W_RESP the next cycle.
  - W_RESP: bvalid=1, bid=latched awid, bresp=2'b00 OKAY or 2'b10 SLVERR. Hold until bready. On handshake, bvalid=0 and return to W_IDLE with awready=1.
  - Write error flag is set, and that beat's write is suppressed, if any of:
    - size>2;
    - beat address >= MEM_DEPTH*4;
    - wlast != (count==len);
    - wid != latched awid;
    - burst is reserved 2'b11;
    - burst is WRAP and the feature is disabled.
  - Beats are still consumed after an error; the error is reported once in bresp.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On handshake, latch fields and load rdata from the first address. rvalid=1 one cycle after the AR handshake.
  - R_DATA: rid=latched arid; rlast=1 when count==len.
  - On rvalid&&rready, advance the address and load the next rdata, so rvalid stays high back-to-back.
  - After the last beat's handshake: rvalid=0, rlast=0, arready=1 the next cycle.
  - rresp=SLVERR per beat under the same error conditions as writes (address, size, burst); rdata=0 on error beats.
  - Outputs are held stable while rvalid=1 and rready=0.
- Address arithmetic:
  - bytes = 1<<size.
  - FIXED (2'b00): address unchanged.
  - INCR (2'b01): addr + bytes, 32-bit wrap-around; no 4 KB check.
  - Unaligned start address: the word index ignores addr[1:0]; lanes are controlled only by wstrb.
- Concurrency:
  - Read and write channels are fully independent.
  - A read fetch and a write beat to the same word in the same cycle: the read returns the old data.
  - Only one outstanding burst per direction; awready/arready stay low until the burst completes.

Optional Feature:
- Macro: AXI_SLV_WRAP_EN.
- Defined: WRAP (2'b10) is supported.
  - Container size = (len+1)*bytes; len must be 1, 3, 7 or 15, else SLVERR.
  - Next address = (addr & ~(container-1)) | ((addr+bytes) & (container-1)).
- Undefined: WRAP is treated as an error burst; beats are consumed and the response is SLVERR.

Test Plan:
- Reset check: hold aresetn=0 for 3 cycles -> awready=1, arready=1, wready=0, bvalid=0, rvalid=0.
- INCR write then read:
  - AW addr=0x100, len=3, size=2, burst=1, id=5; wdata 0xA0..0xA3 with wstrb=4'hF.
  - Expect bresp=0, bid=5.
  - AR with the same fields, id=6 -> rdata 0xA0,0xA1,0xA2,0xA3, rlast on beat 4, rid=6, rresp=0.
- Strobe and FIXED:
  - Write 0x11223344 to 0x20.
  - FIXED write to 0x20, len=1, wstrb=4'b0001 with 0xFF then 4'b0010 with 0xEE00.
  - Read of 0x20 -> 0x1122EEFF.
- Errors:
  - Write to addr=MEM_DEPTH*4 -> bresp=2'b10 and memory unchanged.
  - wlast asserted on beat 1 of a len=2 burst -> SLVERR.
  - Read with size=3 -> rresp=2'b10 on every beat, rdata=0.
- Backpressure and concurrency:
  - rready toggles 1,0,0,1 -> rdata/rlast stable while stalled.
  - A simultaneous write burst completes with bresp=0.
  - bready held low 5 cycles -> bvalid stays high and awready stays 0.
- WRAP burst:
  - With AXI_SLV_WRAP_EN: addr=0x38, len=3, size=2 -> beat addresses 0x38, 0x3C, 0x30, 0x34.
  - Without the macro -> SLVERR.
